// File: rtl/dfa_pkg.sv
// Shared types for the DFA equivalence checker: checker FSM states and config opcodes.
package dfa_pkg;

   typedef enum logic [1:0] {
      CFG  = 2'd0,
      RUN  = 2'd1,
      FAIL = 2'd2
   } chk_state_e;

   typedef enum logic [1:0] {
      OP_TRANS = 2'd0,
      OP_ACC   = 2'd1,
      OP_START = 2'd2
   } cfg_op_e;

   localparam int NUM_DFA = 2;

endpackage

// File: rtl/dfa_engine.sv
// One table-driven DFA: transition table, accept vector, start and current state.
module dfa_engine
   import dfa_pkg::*;
#(
   parameter int STATE_W = 2,
   parameter int SYM_W   = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_we,
   input  logic [1:0]         cfg_op,
   input  logic [STATE_W-1:0] cfg_state,
   input  logic [SYM_W-1:0]   cfg_sym,
   input  logic [STATE_W-1:0] cfg_data,
   input  logic               load_start,
   input  logic               step,
   input  logic [SYM_W-1:0]   sym,
   output logic               out
);

   localparam int NS = 2**STATE_W;
   localparam int NA = 2**SYM_W;

   logic [NS-1:0][NA-1:0][STATE_W-1:0] trans;
   logic [NS-1:0]                      acc;
   logic [STATE_W-1:0]                 start;
   logic [STATE_W-1:0]                 cur;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         trans <= '0;
         acc   <= '0;
         start <= '0;
      end else if (cfg_we) begin
         case (cfg_op_e'(cfg_op))
            OP_TRANS: trans[cfg_state][cfg_sym] <= cfg_data;
            OP_ACC:   acc[cfg_state]            <= cfg_data[0];
            OP_START: start                     <= cfg_data;
            default:  ;
         endcase
      end
   end

   // load_start wins over step; the top never asserts both, but keep it safe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cur <= '0;
      else if (load_start)
         cur <= start;
      else if (step)
         cur <= trans[cur][sym];
   end

   assign out = acc[cur];

endmodule

// File: rtl/dfa_equiv_checker.sv
// Runs a reference and a submitted DFA on one symbol stream and latches the first accept divergence.
module dfa_equiv_checker
   import dfa_pkg::*;
#(
   parameter int STATE_W = 2,
   parameter int SYM_W   = 1,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_we,
   input  logic               cfg_sel,
   input  logic [1:0]         cfg_op,
   input  logic [STATE_W-1:0] cfg_state,
   input  logic [SYM_W-1:0]   cfg_sym,
   input  logic [STATE_W-1:0] cfg_data,
   input  logic               restart,
   input  logic               halt,
   input  logic               sym_valid,
   input  logic [SYM_W-1:0]   sym,
   output logic               run,
   output logic               out_a,
   output logic               out_b,
   output logic               mismatch,
   output logic [CNT_W-1:0]   fail_len,
   output logic [CNT_W-1:0]   sym_cnt
);

   chk_state_e          st;
   logic                differ;
   logic                cfg_ok;
   logic                load_start;
   logic                step;
   logic [NUM_DFA-1:0]  eng_we;
   logic [NUM_DFA-1:0]  eng_out;

   assign differ     = out_a ^ out_b;
   assign load_start = restart & ~halt;
   assign cfg_ok     = cfg_we & ~halt & ~restart & (st == CFG);
   // The comparison takes precedence: a diverged pair never advances.
   assign step       = (st == RUN) & ~halt & ~restart & sym_valid & ~differ;

   genvar g;
   generate
      for (g = 0; g < NUM_DFA; g++) begin : g_eng
         assign eng_we[g] = cfg_ok & (cfg_sel == g[0]);

         dfa_engine #(
            .STATE_W (STATE_W),
            .SYM_W   (SYM_W)
         ) u_eng (
            .clk        (clk),
            .reset      (reset),
            .cfg_we     (eng_we[g]),
            .cfg_op     (cfg_op),
            .cfg_state  (cfg_state),
            .cfg_sym    (cfg_sym),
            .cfg_data   (cfg_data),
            .load_start (load_start),
            .step       (step),
            .sym        (sym),
            .out        (eng_out[g])
         );
      end
   endgenerate

   assign out_a = eng_out[0];
   assign out_b = eng_out[1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st       <= CFG;
         run      <= 1'b0;
         mismatch <= 1'b0;
         fail_len <= '0;
         sym_cnt  <= '0;
      end else if (halt) begin
         st  <= CFG;
         run <= 1'b0;
      end else if (restart) begin
         st       <= RUN;
         run      <= 1'b1;
         mismatch <= 1'b0;
         fail_len <= '0;
         sym_cnt  <= '0;
      end else begin
         case (st)
            RUN: begin
               if (differ) begin
                  st       <= FAIL;
                  run      <= 1'b0;
                  mismatch <= 1'b1;
                  fail_len <= sym_cnt;
               end else if (sym_valid && sym_cnt != {CNT_W{1'b1}}) begin
                  sym_cnt <= sym_cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dfa_equiv_checker.sv
// Directed bench for dfa_equiv_checker; a second instance with CNT_W=3 covers counter saturation.
module tb_dfa_equiv_checker;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       cfg_we = 1'b0;
   logic       cfg_sel = 1'b0;
   logic [1:0] cfg_op = 2'd0;
   logic [1:0] cfg_state = 2'd0;
   logic [0:0] cfg_sym = 1'b0;
   logic [1:0] cfg_data = 2'd0;
   logic       restart = 1'b0;
   logic       halt = 1'b0;
   logic       sym_valid = 1'b0;
   logic [0:0] sym = 1'b0;

   logic        run, out_a, out_b, mismatch;
   logic [15:0] fail_len, sym_cnt;
   logic        run_s, out_a_s, out_b_s, mismatch_s;
   logic [2:0]  fail_len_s, sym_cnt_s;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dfa_equiv_checker #(.STATE_W(2), .SYM_W(1), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_op(cfg_op),
      .cfg_state(cfg_state), .cfg_sym(cfg_sym), .cfg_data(cfg_data), .restart(restart),
      .halt(halt), .sym_valid(sym_valid), .sym(sym), .run(run), .out_a(out_a),
      .out_b(out_b), .mismatch(mismatch), .fail_len(fail_len), .sym_cnt(sym_cnt)
   );

   dfa_equiv_checker #(.STATE_W(2), .SYM_W(1), .CNT_W(3)) dut_sat (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_op(cfg_op),
      .cfg_state(cfg_state), .cfg_sym(cfg_sym), .cfg_data(cfg_data), .restart(restart),
      .halt(halt), .sym_valid(sym_valid), .sym(sym), .run(run_s), .out_a(out_a_s),
      .out_b(out_b_s), .mismatch(mismatch_s), .fail_len(fail_len_s), .sym_cnt(sym_cnt_s)
   );

   // Inputs change and outputs are sampled 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic hard_reset();
      reset = 1'b1;
      #2;
      reset = 1'b0;
      tick();
   endtask

   task automatic wr(input logic sel, input logic [1:0] op, input logic [1:0] st,
                     input logic s, input logic [1:0] d);
      cfg_sel = sel; cfg_op = op; cfg_state = st; cfg_sym = s; cfg_data = d;
      cfg_we = 1'b1;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic feed(input logic s);
      sym = s; sym_valid = 1'b1;
      tick();
      sym_valid = 1'b0;
   endtask

   task automatic do_restart();
      restart = 1'b1;
      tick();
      restart = 1'b0;
   endtask

   task automatic do_halt();
      halt = 1'b1;
      tick();
      halt = 1'b0;
   endtask

   // A accepts in state 2, B in state 3 (optionally not at all).
   task automatic program_pair(input logic b_acc3);
      wr(0, 2'd2, 2'd0, 0, 2'd1);
      wr(0, 2'd0, 2'd1, 0, 2'd1);
      wr(0, 2'd0, 2'd1, 1, 2'd2);
      wr(0, 2'd0, 2'd2, 0, 2'd1);
      wr(0, 2'd0, 2'd2, 1, 2'd2);
      wr(0, 2'd1, 2'd2, 0, 2'd1);
      wr(1, 2'd2, 2'd0, 0, 2'd1);
      wr(1, 2'd0, 2'd1, 0, 2'd1);
      wr(1, 2'd0, 2'd1, 1, 2'd3);
      wr(1, 2'd0, 2'd3, 0, 2'd1);
      wr(1, 2'd0, 2'd3, 1, 2'd3);
      if (b_acc3) wr(1, 2'd1, 2'd3, 0, 2'd1);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #2;
      n_checks++;
      if ({run, out_a, out_b, mismatch} !== 4'b0 || fail_len !== 16'd0 || sym_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got run=%b a=%b b=%b mm=%b fl=%0d cnt=%0d, want all 0",
                  run, out_a, out_b, mismatch, fail_len, sym_cnt);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_equivalent();
      logic [3:0] syms;
      logic [3:0] exp_out;
      syms    = 4'b0110;
      exp_out = 4'b0110;
      hard_reset();
      program_pair(1'b1);
      do_restart();
      n_checks++;
      if (run !== 1'b1) begin
         n_fail++; $display("FAIL equiv_run: got %b want 1", run);
      end
      for (int i = 0; i < 4; i++) begin
         feed(syms[3-i]);
         n_checks++;
         if (out_a !== exp_out[3-i] || out_b !== exp_out[3-i]) begin
            n_fail++;
            $display("FAIL equiv_out[%0d]: got a=%b b=%b want %b", i, out_a, out_b, exp_out[3-i]);
         end
      end
      tick();
      n_checks++;
      if (mismatch !== 1'b0 || sym_cnt !== 16'd4 || run !== 1'b1) begin
         n_fail++;
         $display("FAIL equiv_final: got mm=%b cnt=%0d run=%b want 0 4 1", mismatch, sym_cnt, run);
      end
   endtask

   task automatic test_diverge();
      hard_reset();
      program_pair(1'b0);
      do_restart();
      feed(1'b1);
      n_checks++;
      if (out_a !== 1'b1 || out_b !== 1'b0 || mismatch !== 1'b0 || sym_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL diverge_step: got a=%b b=%b mm=%b cnt=%0d want 1 0 0 1",
                  out_a, out_b, mismatch, sym_cnt);
      end
      feed(1'b0);
      n_checks++;
      if (mismatch !== 1'b1 || fail_len !== 16'd1 || run !== 1'b0) begin
         n_fail++;
         $display("FAIL diverge_latch: got mm=%b fl=%0d run=%b want 1 1 0", mismatch, fail_len, run);
      end
      feed(1'b0);
      feed(1'b1);
      n_checks++;
      if (sym_cnt !== 16'd1 || out_a !== 1'b1 || mismatch !== 1'b1) begin
         n_fail++;
         $display("FAIL diverge_frozen: got cnt=%0d a=%b mm=%b want 1 1 1", sym_cnt, out_a, mismatch);
      end
   endtask

   task automatic test_empty_string();
      hard_reset();
      wr(0, 2'd1, 2'd0, 0, 2'd1);
      do_restart();
      n_checks++;
      if (run !== 1'b1 || mismatch !== 1'b0 || out_a !== 1'b1 || out_b !== 1'b0) begin
         n_fail++;
         $display("FAIL empty_first: got run=%b mm=%b a=%b b=%b want 1 0 1 0", run, mismatch, out_a, out_b);
      end
      tick();
      n_checks++;
      if (mismatch !== 1'b1 || fail_len !== 16'd0 || run !== 1'b0) begin
         n_fail++;
         $display("FAIL empty_latch: got mm=%b fl=%0d run=%b want 1 0 0", mismatch, fail_len, run);
      end
   endtask

   task automatic test_cfg_gating();
      hard_reset();
      program_pair(1'b1);
      do_restart();
      wr(1, 2'd0, 2'd1, 1, 2'd0);
      feed(1'b1);
      n_checks++;
      if (out_b !== 1'b1 || mismatch !== 1'b0) begin
         n_fail++; $display("FAIL cfg_in_run: got b=%b mm=%b want 1 0", out_b, mismatch);
      end
      do_halt();
      n_checks++;
      if (run !== 1'b0 || sym_cnt !== 16'd1) begin
         n_fail++; $display("FAIL halt_hold: got run=%b cnt=%0d want 0 1", run, sym_cnt);
      end
      wr(1, 2'd0, 2'd1, 1, 2'd0);
      do_restart();
      feed(1'b1);
      n_checks++;
      if (out_a !== 1'b1 || out_b !== 1'b0) begin
         n_fail++; $display("FAIL cfg_in_cfg: got a=%b b=%b want 1 0", out_a, out_b);
      end
      tick();
      n_checks++;
      if (mismatch !== 1'b1 || fail_len !== 16'd1) begin
         n_fail++; $display("FAIL cfg_in_cfg_latch: got mm=%b fl=%0d want 1 1", mismatch, fail_len);
      end
   endtask

   task automatic test_back_to_back();
      hard_reset();
      program_pair(1'b1);
      sym = 1'b1; sym_valid = 1'b1; restart = 1'b1;
      tick();
      restart = 1'b0; sym_valid = 1'b0;
      n_checks++;
      if (sym_cnt !== 16'd0 || out_a !== 1'b0 || run !== 1'b1) begin
         n_fail++;
         $display("FAIL restart_drop: got cnt=%0d a=%b run=%b want 0 0 1", sym_cnt, out_a, run);
      end
      feed(1'b1);
      halt = 1'b1; restart = 1'b1;
      tick();
      halt = 1'b0; restart = 1'b0;
      n_checks++;
      if (run !== 1'b0 || sym_cnt !== 16'd1) begin
         n_fail++; $display("FAIL halt_over_restart: got run=%b cnt=%0d want 0 1", run, sym_cnt);
      end
      feed(1'b0);
      n_checks++;
      if (sym_cnt !== 16'd1 || out_a !== 1'b1) begin
         n_fail++; $display("FAIL cfg_ignores_sym: got cnt=%0d a=%b want 1 1", sym_cnt, out_a);
      end
   endtask

   task automatic test_async_reset();
      hard_reset();
      program_pair(1'b1);
      do_restart();
      feed(1'b0); feed(1'b1); feed(1'b1);
      n_checks++;
      if (sym_cnt !== 16'd3 || out_a !== 1'b1) begin
         n_fail++; $display("FAIL pre_reset: got cnt=%0d a=%b want 3 1", sym_cnt, out_a);
      end
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if ({run, out_a, out_b, mismatch} !== 4'b0 || sym_cnt !== 16'd0 || fail_len !== 16'd0) begin
         n_fail++;
         $display("FAIL async_reset: got run=%b a=%b b=%b mm=%b cnt=%0d, want all 0",
                  run, out_a, out_b, mismatch, sym_cnt);
      end
      reset = 1'b0;
      tick();
      do_restart();
      feed(1'b1);
      feed(1'b1);
      n_checks++;
      if (out_a !== 1'b0 || out_b !== 1'b0 || mismatch !== 1'b0 || sym_cnt !== 16'd2) begin
         n_fail++;
         $display("FAIL tables_cleared: got a=%b b=%b mm=%b cnt=%0d want 0 0 0 2",
                  out_a, out_b, mismatch, sym_cnt);
      end
   endtask

   task automatic test_saturate();
      hard_reset();
      do_restart();
      for (int i = 0; i < 9; i++) feed(i[0]);
      n_checks++;
      if (sym_cnt_s !== 3'd7 || sym_cnt !== 16'd9 || mismatch_s !== 1'b0 || run_s !== 1'b1) begin
         n_fail++;
         $display("FAIL saturate: got small=%0d wide=%0d mm=%b run=%b want 7 9 0 1",
                  sym_cnt_s, sym_cnt, mismatch_s, run_s);
      end
      feed(1'b1);
      n_checks++;
      if (sym_cnt_s !== 3'd7 || fail_len_s !== 3'd0 || out_a_s !== out_b_s) begin
         n_fail++;
         $display("FAIL saturate_hold: got cnt=%0d fl=%0d a=%b b=%b want 7 0 equal",
                  sym_cnt_s, fail_len_s, out_a_s, out_b_s);
      end
   endtask

   initial begin
      #3;
      test_reset();
      test_equivalent();
      test_diverge();
      test_empty_string();
      test_cfg_gating();
      test_back_to_back();
      test_async_reset();
      test_saturate();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
